// File: rtl/axi_pwm_s_axi_regs.sv
// axi_pwm_s_axi_regs: AXI4-Lite slave holding CTRL/PERIOD/DUTY/SCRATCH
// and driving a PWM output from double-buffered PERIOD/DUTY shadows.
module axi_pwm_s_axi_regs #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 4
) (
   input  logic                              s00_axi_aclk,
   input  logic                              s00_axi_aresetn,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_awaddr,
   input  logic [2:0]                        s00_axi_awprot,
   input  logic                              s00_axi_awvalid,
   output logic                              s00_axi_awready,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_wdata,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   s00_axi_wstrb,
   input  logic                              s00_axi_wvalid,
   output logic                              s00_axi_wready,
   output logic [1:0]                        s00_axi_bresp,
   output logic                              s00_axi_bvalid,
   input  logic                              s00_axi_bready,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_araddr,
   input  logic [2:0]                        s00_axi_arprot,
   input  logic                              s00_axi_arvalid,
   output logic                              s00_axi_arready,
   output logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_rdata,
   output logic [1:0]                        s00_axi_rresp,
   output logic                              s00_axi_rvalid,
   input  logic                              s00_axi_rready,
   output logic                              pwm_out
);
   localparam logic [C_S_AXI_DATA_WIDTH-1:0] one = 1;
   logic [C_S_AXI_DATA_WIDTH-1:0] regs [4];
   logic [C_S_AXI_DATA_WIDTH-1:0] cnt, per_act, duty_act;
   logic [1:0] araddr_q;
   logic wr_hs, rd_hs, ar_take, aw_take, en, load, unused;
   always_comb begin
      wr_hs   = s00_axi_awready && s00_axi_awvalid && s00_axi_wready && s00_axi_wvalid;
      rd_hs   = s00_axi_arready && s00_axi_arvalid;
      aw_take = s00_axi_awvalid && s00_axi_wvalid && !s00_axi_awready && !s00_axi_bvalid;
      ar_take = s00_axi_arvalid && !s00_axi_arready && !s00_axi_rvalid;
      en      = regs[0][0];
      // shadows reload at wrap, while disabled, or while the active period is zero
      load    = !en || per_act == '0 || cnt == per_act - one;
      unused  = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};
   end
   assign s00_axi_bresp = 2'b00;
   assign s00_axi_rresp = 2'b00;
   always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn)
      if (!s00_axi_aresetn) begin
         s00_axi_awready <= 1'b0;
         s00_axi_wready  <= 1'b0;
         s00_axi_bvalid  <= 1'b0;
      end else begin
         s00_axi_awready <= aw_take;
         s00_axi_wready  <= aw_take;
         s00_axi_bvalid  <= wr_hs || (s00_axi_bvalid && !s00_axi_bready);
      end
   always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn)
      if (!s00_axi_aresetn) begin
         for (int i = 0; i < 4; i++) regs[i] <= '0;
      end else if (wr_hs) begin
         for (int b = 0; b < C_S_AXI_DATA_WIDTH/8; b++)
            if (s00_axi_wstrb[b]) regs[s00_axi_awaddr[3:2]][8*b +: 8] <= s00_axi_wdata[8*b +: 8];
      end
   always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn)
      if (!s00_axi_aresetn) begin
         s00_axi_arready <= 1'b0;
         s00_axi_rvalid  <= 1'b0;
         s00_axi_rdata   <= '0;
         araddr_q        <= '0;
      end else begin
         s00_axi_arready <= ar_take;
         if (ar_take) araddr_q <= s00_axi_araddr[3:2];
         if (rd_hs) s00_axi_rdata <= regs[araddr_q];
         s00_axi_rvalid  <= rd_hs || (s00_axi_rvalid && !s00_axi_rready);
      end
   always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn)
      if (!s00_axi_aresetn) begin
         cnt      <= '0;
         per_act  <= '0;
         duty_act <= '0;
         pwm_out  <= 1'b0;
      end else begin
         cnt <= load ? '0 : cnt + one;
         if (load) begin
            per_act  <= regs[1];
            duty_act <= regs[2];
         end
         pwm_out <= en && per_act != '0 && cnt < duty_act;
      end
endmodule

// File: tb/tb_axi_pwm_s_axi_regs.sv
// tb_axi_pwm_s_axi_regs: randomized AXI4-Lite traffic against a register/PWM
// reference model that tracks whole PWM periods as queued bit patterns.
module tb_axi_pwm_s_axi_regs;
   logic clk = 0, rst_n = 0;
   logic [3:0] awaddr = 0, araddr = 0, wstrb = 0;
   logic [2:0] awprot = 0, arprot = 0;
   logic [31:0] wdata = 0;
   logic awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
   logic awready, wready, bvalid, arready, rvalid, pwm_out;
   logic [1:0] bresp, rresp;
   logic [31:0] rdata;
   int n_chk = 0, n_pass = 0;
   logic [31:0] m_regs [4];
   logic [31:0] sp = 0, sd = 0, exp_rd = 0;
   logic exp_pwm = 0;
   bit q[$];

   axi_pwm_s_axi_regs dut (
      .s00_axi_aclk(clk), .s00_axi_aresetn(rst_n),
      .s00_axi_awaddr(awaddr), .s00_axi_awprot(awprot), .s00_axi_awvalid(awvalid), .s00_axi_awready(awready),
      .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb), .s00_axi_wvalid(wvalid), .s00_axi_wready(wready),
      .s00_axi_bresp(bresp), .s00_axi_bvalid(bvalid), .s00_axi_bready(bready),
      .s00_axi_araddr(araddr), .s00_axi_arprot(arprot), .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
      .s00_axi_rdata(rdata), .s00_axi_rresp(rresp), .s00_axi_rvalid(rvalid), .s00_axi_rready(rready),
      .pwm_out(pwm_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h want %h", tag, obs, exp);
   endtask

   // reference model, evaluated mid-cycle with the values the next rising edge will see
   initial forever begin
      @(negedge clk);
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) m_regs[i] = 0;
         q.delete();
         sp = 0;
         sd = 0;
         exp_pwm = 0;
         chk("pwm_in_reset", {31'b0, pwm_out}, 0);
      end else begin
         chk("pwm", {31'b0, pwm_out}, {31'b0, exp_pwm});
         if (!m_regs[0][0]) begin
            q.delete();
            sp = m_regs[1];
            sd = m_regs[2];
            exp_pwm = 0;
         end else begin
            if (q.size() == 0) for (int i = 0; i < int'(sp); i++) q.push_back(i < int'(sd));
            exp_pwm = (q.size() == 0) ? 1'b0 : q.pop_front();
            if (q.size() == 0) begin
               sp = m_regs[1];
               sd = m_regs[2];
            end
         end
         if (arready && arvalid) exp_rd = m_regs[araddr[3:2]];
         if (awready && awvalid && wready && wvalid)
            for (int b = 0; b < 4; b++) if (wstrb[b]) m_regs[awaddr[3:2]][8*b +: 8] = wdata[8*b +: 8];
      end
   end

   task automatic write_begin(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                              input int lead, input bit w_first);
      int n = 0;
      @(posedge clk); #1;
      if (w_first) begin wdata = d; wstrb = s; wvalid = 1; end
      else begin awaddr = a; awvalid = 1; end
      repeat (lead) begin @(posedge clk); #1; chk("lone_accept", {30'b0, awready, wready}, 0); end
      awaddr = a; awvalid = 1; wdata = d; wstrb = s; wvalid = 1;
      while (!awready && n < 20) begin @(posedge clk); #1; n++; end
      chk("awready", {31'b0, awready}, 1);
      chk("wready", {31'b0, wready}, 1);
      @(posedge clk); #1;
      awvalid = 0; wvalid = 0;
      chk("aw_pulse", {31'b0, awready}, 0);
      chk("bvalid", {31'b0, bvalid}, 1);
      chk("bresp", {30'b0, bresp}, 0);
   endtask

   task automatic write_end(input int bd);
      repeat (bd) begin @(posedge clk); #1; chk("b_hold", {31'b0, bvalid}, 1); end
      bready = 1;
      @(posedge clk); #1;
      bready = 0;
      chk("b_drop", {31'b0, bvalid}, 0);
   endtask

   task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
      write_begin(a, d, s, 0, 0);
      write_end(0);
   endtask

   task automatic axi_read(input logic [3:0] a, input int rd, output logic [31:0] v);
      int n = 0;
      @(posedge clk); #1;
      araddr = a; arvalid = 1;
      while (!arready && n < 20) begin @(posedge clk); #1; n++; end
      chk("arready", {31'b0, arready}, 1);
      @(posedge clk); #1;
      arvalid = 0;
      chk("rvalid", {31'b0, rvalid}, 1);
      chk("rdata", rdata, exp_rd);
      chk("rresp", {30'b0, rresp}, 0);
      v = rdata;
      repeat (rd) begin
         @(posedge clk); #1;
         chk("r_hold", {31'b0, rvalid}, 1);
         chk("r_stable", rdata, exp_rd);
      end
      rready = 1;
      @(posedge clk); #1;
      rready = 0;
      chk("r_drop", {31'b0, rvalid}, 0);
   endtask

   task automatic wait_level(input logic lv);
      int n = 0;
      while (pwm_out !== lv && n < 200) begin @(posedge clk); #1; n++; end
      chk("wait_pwm", {31'b0, pwm_out}, {31'b0, lv});
   endtask

   task automatic run_len(input logic lv, output int n);
      n = 0;
      while (pwm_out === lv && n < 200) begin n++; @(posedge clk); #1; end
   endtask

   task automatic count_high(input int len, output int c);
      c = 0;
      repeat (len) begin @(posedge clk); #1; c += int'(pwm_out); end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: run did not finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] v, d;
      logic [3:0] s;
      int h, l, c, a;
      #2;
      chk("rst_awready", {31'b0, awready}, 0);
      chk("rst_wready", {31'b0, wready}, 0);
      chk("rst_bvalid", {31'b0, bvalid}, 0);
      chk("rst_arready", {31'b0, arready}, 0);
      chk("rst_rvalid", {31'b0, rvalid}, 0);
      chk("rst_rdata", rdata, 0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1;
      // basic register write/read-back
      for (int i = 0; i < 4; i++) axi_write(4'(i*4), 32'(i+1), 4'hF);
      for (int i = 0; i < 4; i++) begin axi_read(4'(i*4), 0, v); chk("rdback", v, 32'(i+1)); end
      // byte strobes
      axi_write(4'hC, 32'hAABBCCDD, 4'hF);
      axi_write(4'hC, 32'h11223344, 4'b0101);
      axi_read(4'hC, 2, v);
      chk("strb_merge", v, 32'hAA22CC44);
      // 3-of-10 waveform, then a mid-period duty change
      axi_write(4'h0, 0, 4'hF);
      axi_write(4'h4, 10, 4'hF);
      axi_write(4'h8, 3, 4'hF);
      axi_write(4'h0, 1, 4'hF);
      wait_level(0);
      wait_level(1);
      run_len(1, h);
      run_len(0, l);
      chk("high_3", 32'(h), 3);
      chk("low_7", 32'(l), 7);
      axi_write(4'h8, 7, 4'hF);
      wait_level(0);
      wait_level(1);
      run_len(1, h);
      chk("high_7", 32'(h), 7);
      // duty >= period, zero period, disable
      axi_write(4'h8, 12, 4'hF);
      repeat (12) @(posedge clk);
      count_high(20, c);
      chk("duty_ge_per", 32'(c), 20);
      axi_write(4'h4, 0, 4'hF);
      repeat (12) @(posedge clk);
      count_high(20, c);
      chk("per_zero", 32'(c), 0);
      axi_write(4'h4, 10, 4'hF);
      repeat (12) @(posedge clk);
      write_begin(4'h0, 0, 4'hF, 0, 0);
      @(posedge clk); #1;
      chk("en_off", {31'b0, pwm_out}, 0);
      write_end(0);
      // lone AW ahead of W, held response stalls the next write
      write_begin(4'hC, 32'h5A5A, 4'hF, 5, 0);
      awaddr = 4'hC; wdata = 32'h1234; wstrb = 4'hF; awvalid = 1; wvalid = 1;
      repeat (4) begin
         @(posedge clk); #1;
         chk("b_held", {31'b0, bvalid}, 1);
         chk("aw_stalled", {31'b0, awready}, 0);
      end
      write_end(0);
      write_begin(4'hC, 32'h1234, 4'hF, 0, 0);
      write_end(1);
      axi_read(4'hC, 0, v);
      chk("stalled_wr", v, 32'h1234);
      write_begin(4'h4, 32'd6, 4'hF, 3, 1);
      write_end(2);
      // coincident read and write of the same register
      axi_write(4'hC, 32'h0BAD, 4'hF);
      fork
         begin write_begin(4'hC, 32'h600D, 4'hF, 0, 0); write_end(0); end
         axi_read(4'hC, 0, v);
      join
      chk("rw_pre", v, 32'h0BAD);
      axi_read(4'hC, 0, v);
      chk("rw_post", v, 32'h600D);
      // random traffic
      for (int k = 0; k < 80; k++) begin
         a = int'($urandom_range(0, 3));
         if ($urandom_range(0, 2) == 0) axi_read(4'(a*4), int'($urandom_range(0, 3)), v);
         else begin
            if (a == 1 || a == 2) begin d = $urandom_range(0, 12); s = 4'hF; end
            else begin d = $urandom; s = 4'($urandom_range(0, 15)); end
            write_begin(4'(a*4), d, s, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            write_end(int'($urandom_range(0, 3)));
         end
         repeat ($urandom_range(0, 12)) @(posedge clk);
      end
      // reset while a response is pending and the output is high
      axi_write(4'h4, 4, 4'hF);
      axi_write(4'h8, 4, 4'hF);
      axi_write(4'h0, 1, 4'hF);
      repeat (10) @(posedge clk);
      #1 chk("pwm_pre_rst", {31'b0, pwm_out}, 1);
      write_begin(4'hC, 32'hDEAD, 4'hF, 0, 0);
      chk("b_pre_rst", {31'b0, bvalid}, 1);
      #2 rst_n = 0;
      #1;
      chk("arst_bvalid", {31'b0, bvalid}, 0);
      chk("arst_pwm", {31'b0, pwm_out}, 0);
      chk("arst_awready", {31'b0, awready}, 0);
      chk("arst_rvalid", {31'b0, rvalid}, 0);
      chk("arst_rdata", rdata, 0);
      awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1;
      for (int i = 0; i < 4; i++) begin axi_read(4'(i*4), 0, v); chk("post_rst", v, 0); end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
